// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the PC sequencer: FSM states, redirect kinds,
// the fetch increment and the J-type target builder.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_JUMP   = 2'd2
    } redir_e;

    localparam logic [31:0] PC_INCR = 32'd4;

    function automatic logic [31:0] jump_addr(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
        return {pc_plus4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_mux.sv
// Combinational next-PC select: jump beats branch, otherwise fall through to
// pc+4. Also reports which redirect won and whether its target is misaligned.
module pc_redirect_mux
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    output logic [31:0] next_pc_o,
    output redir_e      kind_o,
    output logic        misalign_o
);

    always_comb begin
        next_pc_o = pc_plus4_i;
        kind_o    = RD_NONE;
        if (jump_i) begin
            next_pc_o = jump_addr(pc_plus4_i, jump_index_i);
            kind_o    = RD_JUMP;
        end else if (branch_taken_i) begin
            next_pc_o = branch_target_i;
            kind_o    = RD_BRANCH;
        end
    end

    // Fall-through is always word aligned, so only real redirects can trap.
    assign misalign_o = (kind_o != RD_NONE) && (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// PC owner for the single-cycle MIPS datapath: boot/run/stall/halt FSM, a
// one-entry pending redirect captured during stalls, and misaligned-target trap.
// Optional taken-branch/jump counters are built when BRANCH_STATS_EN is defined.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          STAT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              fetch_valid,
    output logic              misalign_err,
    output logic              halted,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] jump_cnt,
    output state_e            state_dbg
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        err_q, err_d;

    logic [31:0] mux_next_pc;
    redir_e      mux_kind;
    logic        mux_misalign;

`ifdef BRANCH_STATS_EN
    redir_e      pend_kind_q, pend_kind_d;
    redir_e      apply_kind;
`endif

    assign pc_plus4 = pc_q + PC_INCR;

    pc_redirect_mux u_mux (
        .pc_plus4_i      (pc_plus4),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_index_i    (jump_index),
        .next_pc_o       (mux_next_pc),
        .kind_o          (mux_kind),
        .misalign_o      (mux_misalign)
    );

    // Priority in RUN/STALL: halt, then misaligned redirect, then stall.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        err_d        = err_q;
`ifdef BRANCH_STATS_EN
        pend_kind_d  = pend_kind_q;
        apply_kind   = RD_NONE;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (halt_req) begin
                    state_d      = ST_HALT;
                    pend_valid_d = 1'b0;
                end else if (mux_misalign) begin
                    state_d      = ST_HALT;
                    err_d        = 1'b1;
                    pend_valid_d = 1'b0;
                end else if (stall) begin
                    state_d = ST_STALL;
                    if (mux_kind != RD_NONE) begin
                        pend_valid_d = 1'b1;
                        pend_pc_d    = mux_next_pc;
`ifdef BRANCH_STATS_EN
                        pend_kind_d  = mux_kind;
`endif
                    end
                end else begin
                    state_d      = ST_RUN;
                    pend_valid_d = 1'b0;
                    if (mux_kind != RD_NONE || state_q == ST_RUN || !pend_valid_q) begin
                        pc_d = mux_next_pc;
`ifdef BRANCH_STATS_EN
                        apply_kind = mux_kind;
`endif
                    end else if (pend_pc_q[1:0] != 2'b00) begin
                        state_d = ST_HALT;
                        err_d   = 1'b1;
                    end else begin
                        pc_d = pend_pc_q;
`ifdef BRANCH_STATS_EN
                        apply_kind = pend_kind_q;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            err_q        <= err_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] branch_cnt_q, jump_cnt_q;

    // Counters saturate so a long-running program never wraps the statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_kind_q  <= RD_NONE;
            branch_cnt_q <= '0;
            jump_cnt_q   <= '0;
        end else begin
            pend_kind_q <= pend_kind_d;
            if (apply_kind == RD_BRANCH && branch_cnt_q != '1)
                branch_cnt_q <= branch_cnt_q + 1'b1;
            if (apply_kind == RD_JUMP && jump_cnt_q != '1)
                jump_cnt_q <= jump_cnt_q + 1'b1;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign jump_cnt   = jump_cnt_q;
`else
    assign branch_cnt = '0;
    assign jump_cnt   = '0;
`endif

    assign pc           = pc_q;
    assign fetch_valid  = (state_q == ST_RUN) || (state_q == ST_STALL);
    assign halted       = (state_q == ST_HALT);
    assign misalign_err = err_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer: each record drives one cycle and
// carries the outputs expected after the following rising edge.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam logic [31:0] RV     = 32'h0040_0000;
    localparam int          STAT_W = 16;
    localparam int          EW     = 32 + 32 + 3 + 2 * STAT_W;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              halt_req;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic              jump;
    logic [25:0]       jump_index;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              fetch_valid;
    logic              misalign_err;
    logic              halted;
    logic [STAT_W-1:0] branch_cnt;
    logic [STAT_W-1:0] jump_cnt;
    state_e            state_dbg;

    pc_sequencer #(.RESET_VECTOR(RV), .STAT_W(STAT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .halt_req      (halt_req),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .misalign_err  (misalign_err),
        .halted        (halted),
        .branch_cnt    (branch_cnt),
        .jump_cnt      (jump_cnt),
        .state_dbg     (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        hlt;
        logic        br;
        logic [31:0] tgt;
        logic        jmp;
        logic [25:0] idx;
        logic [31:0] e_pc;
        logic        e_fv;
        logic        e_hl;
        logic        e_er;
        int          e_bc;
        int          e_jc;
    } vec_t;

    vec_t           tbl[$];
    logic [EW-1:0]  exp_q[$];
    int             checks = 0;
    int             errors = 0;

    function automatic vec_t mk(logic rst, logic stl, logic hlt, logic br,
                                logic [31:0] tgt, logic jmp, logic [25:0] idx,
                                logic [31:0] e_pc, logic e_fv, logic e_hl,
                                logic e_er, int e_bc, int e_jc);
        vec_t v;
        v.rst = rst; v.stl = stl; v.hlt = hlt; v.br = br; v.tgt = tgt;
        v.jmp = jmp; v.idx = idx; v.e_pc = e_pc; v.e_fv = e_fv;
        v.e_hl = e_hl; v.e_er = e_er; v.e_bc = e_bc; v.e_jc = e_jc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int step);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    // Scoreboard: pop the oldest expectation and compare it to the DUT outputs.
    task automatic check_out(input int step);
        logic [EW-1:0]     e;
        logic [31:0]       e_pc;
        logic              e_fv, e_hl, e_er;
        logic [STAT_W-1:0] e_bc, e_jc;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty step %0d: got 0 entries expected 1", step);
        end else begin
            e = exp_q.pop_front();
            {e_pc, e_fv, e_hl, e_er, e_bc, e_jc} = e[EW-33:0];
            chk("pc", pc, e_pc, step);
            chk("pc_plus4", pc_plus4, e[EW-1:EW-32], step);
            chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e_fv}, step);
            chk("halted", {31'b0, halted}, {31'b0, e_hl}, step);
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, e_er}, step);
            chk("branch_cnt", {{(32-STAT_W){1'b0}}, branch_cnt}, {{(32-STAT_W){1'b0}}, e_bc}, step);
            chk("jump_cnt", {{(32-STAT_W){1'b0}}, jump_cnt}, {{(32-STAT_W){1'b0}}, e_jc}, step);
        end
    endtask

    // Driver: apply one record, push its expectation, sample #1 after the edge.
    task automatic apply_vec(input vec_t v, input int step);
        logic [STAT_W-1:0] bc, jc;
`ifdef BRANCH_STATS_EN
        bc = STAT_W'(v.e_bc);
        jc = STAT_W'(v.e_jc);
`else
        bc = '0;
        jc = '0;
`endif
        reset         = v.rst;
        stall         = v.stl;
        halt_req      = v.hlt;
        branch_taken  = v.br;
        branch_target = v.tgt;
        jump          = v.jmp;
        jump_index    = v.idx;
        exp_q.push_back({v.e_pc + 32'd4, v.e_pc, v.e_fv, v.e_hl, v.e_er, bc, jc});
        @(posedge clk);
        #1;
        check_out(step);
    endtask

    initial begin
        int n_stall;
        reset = 1'b1; stall = 1'b0; halt_req = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; jump = 1'b0; jump_index = 26'h0;

        //            rst stl hlt br  tgt            jmp idx         e_pc          fv hl er bc jc
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         0, 26'h0,       RV,           0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0040_0100, 0, 26'h0,       RV,           1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,       32'h0040_0004, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0040_0100, 0, 26'h0,       32'h0040_0100, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,       32'h0040_0104, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h1000_0000, 0, 26'h0,       32'h1000_0000, 1, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h2000_0000, 1, 26'h000_0040, 32'h1000_0100, 1, 0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,         0, 26'h0,       32'h1000_0100, 1, 0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 0, 1, 32'h0000_0200, 0, 26'h0,       32'h1000_0100, 1, 0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,         0, 26'h0,       32'h1000_0100, 1, 0, 0, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,       32'h0000_0200, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,       32'h0000_0204, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,         0, 26'h0,       32'h0000_0204, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,       32'h0000_0208, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 1, 0, 1, 32'h0000_0300, 0, 26'h0,       32'h0000_0208, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 1, 0, 1, 32'h0000_0400, 0, 26'h0,       32'h0000_0208, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         1, 26'h000_0080, 32'h0000_0200, 1, 0, 0, 3, 2));
        tbl.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 26'h0,       32'hFFFF_FFFC, 1, 0, 0, 4, 2));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,       32'h0000_0000, 1, 0, 0, 4, 2));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,       32'h0000_0004, 1, 0, 0, 4, 2));
        tbl.push_back(mk(0, 1, 1, 1, 32'h0000_0100, 0, 26'h0,       32'h0000_0004, 0, 1, 0, 4, 2));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0000_0500, 0, 26'h0,       32'h0000_0004, 0, 1, 0, 4, 2));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         0, 26'h0,       RV,           0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,       RV,           1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0040_0202, 0, 26'h0,       RV,           0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,       RV,           0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         0, 26'h0,       RV,           0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,       RV,           1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h0040_0300, 0, 26'h0,       RV,           1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,         0, 26'h0,       RV,           0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         0, 26'h0,       RV,           0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,       RV,           1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,         0, 26'h0,       RV,           1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         0, 26'h0,       RV,           0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,         0, 26'h0,       RV,           1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         0, 26'h0,       32'h0040_0004, 1, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply_vec(tbl[i], i);

        // Hand sequence: jump latched on the first stall cycle of a random-length
        // stall must be applied exactly once on release.
        n_stall = $urandom_range(2, 6);
        apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 26'h010_0040, 32'h0040_0004, 1, 0, 0, 0, 0), 100);
        for (int k = 1; k < n_stall; k++)
            apply_vec(mk(0, 1, 0, 0, 32'h0, 0, 26'h0, 32'h0040_0004, 1, 0, 0, 0, 0), 100 + k);
        apply_vec(mk(0, 0, 0, 0, 32'h0, 0, 26'h0, 32'h0040_0100, 1, 0, 0, 0, 1), 200);
        apply_vec(mk(0, 0, 0, 0, 32'h0, 0, 26'h0, 32'h0040_0104, 1, 0, 0, 0, 1), 201);

        // Hand sequence: a misaligned branch while stalled traps immediately.
        apply_vec(mk(0, 1, 0, 1, 32'h0040_0401, 0, 26'h0, 32'h0040_0104, 0, 1, 1, 0, 1), 300);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
